pg_alu_ctrl: RTL and testbench
==============================

# pg_alu_ctrl

Parametrised, power-managed ALU block and the successor to the fixed 16-bit isolated ALU wrapper. It adds three things the fixed wrapper lacks: an internal power sequencer that drives the ALU's power-enable and isolation controls, a ready/done operation handshake, and a multi-cycle multiply. It sits between the core's issue logic and the switchable ALU domain. Outputs are clamped to zero whenever the domain is isolated.

## Interface
Parameters:
- WIDTH, 16: operand and result width; must be ≥ 4.
- PWR_UP_CYC, 4: cycles spent in power-up settle before isolation is released; must be ≥ 1.
- MUL_LAT, 3: cycles from multiply accept to done; must be ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- pwr_req  in  1  level; 1 = domain requested on.
- A, B  in  WIDTH  operands, sampled on accept.
- opcode  in  4  operation, sampled on accept.
- start  in  1  operation request.
- ready  out  1  block can accept an operation this cycle.
- done  out  1  one-cycle pulse; result and carry are valid.
- result  out  WIDTH  last completed result; 0 while iso_en=1.
- carry  out  1  ADD carry-out or SUB borrow; 0 for other ops and while isolated.
- alu_pwr_en  out  1  power switch enable for the ALU domain.
- iso_en  out  1  isolation enable; 1 = outputs clamped.
- pwr_on  out  1  1 exactly in state ON.
- drop  out  1  one-cycle pulse when start=1 and ready=0.

## Operation
Power FSM states:
- OFF: alu_pwr_en=0, iso_en=1. If pwr_req=1, go to PUP.
- PUP: alu_pwr_en=1, iso_en=1. Settle counter runs for PWR_UP_CYC cycles, then go to ON. If pwr_req=0 before the count ends, go to PDN.
- ON: alu_pwr_en=1, iso_en=0. If pwr_req=0 and an op is busy, go to DRAIN. If pwr_req=0 and idle, go to PDN.
- DRAIN: alu_pwr_en=1, iso_en=0, ready=0. Go to PDN on the cycle done pulses.
- PDN: alu_pwr_en=1, iso_en=1 for one cycle, then go to OFF.

Datapath registers (result, carry, multiply counter) clear to 0 on entry to OFF. State is not retained across power-off.

Handshake:
- ready = (state==ON) && !busy.
- An op is accepted on start && ready.
- start && !ready is ignored and pulses drop.

Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A.
- 6 SHL A by B[$clog2(WIDTH)-1:0]; 7 SHR (logical), same shift amount.
- 8 MUL: low WIDTH bits of A*B, multi-cycle.
- 9 PASS A.
- 10–15: result 0, carry 0; done still pulses.

Arithmetic:
- All arithmetic is modulo 2^WIDTH.
- SUB carry = 1 when A < B (unsigned borrow).

## Timing
- Reset values: state OFF, alu_pwr_en 0, iso_en 1, pwr_on 0, ready 0, done 0, drop 0, result 0, carry 0.
- Power-up: pwr_req rises in cycle t → PUP from t+1 → ON at t+1+PWR_UP_CYC, and ready=1 in that same cycle.
- Non-MUL ops: accepted in cycle t → done=1 and result valid in t+1. ready stays 1, so back-to-back issue is allowed.
- MUL: accepted in cycle t → busy, ready=0 for t+1 … t+MUL_LAT-1 → done in t+MUL_LAT. ready returns to 1 in t+MUL_LAT.
- result and carry hold their value between done pulses. They read 0 whenever iso_en=1, then show the held value again once isolation drops; after a power-off the held value is 0.
- pwr_req falls in the same cycle as an accepted start: the op completes, via DRAIN if it is a MUL.
- DRAIN → PDN on the done cycle, so that done pulse is still visible un-isolated.
- pwr_req toggles during PDN: PDN always finishes into OFF; re-power-up starts from OFF.
- rst_n asserted mid-operation: immediate return to reset values. Any pending done is lost.

## Structure
- Package pg_alu_pkg: opcode enum (OP_ADD … OP_PASS), power-state enum (PS_OFF, PS_PUP, PS_ON, PS_DRAIN, PS_PDN).
- Sub-module pg_alu_datapath: operand capture, op decode, MUL latency counter, result and carry registers, busy/done generation, and clear-on-power-off input.
- The top level holds the power FSM, the settle counter, ready/drop logic and the isolation clamp on the outputs.

## Test plan
Defaults throughout: WIDTH=16, PWR_UP_CYC=4, MUL_LAT=3.
- Reset, then pwr_req=1 at cycle 0 → iso_en=1 for cycles 1–4, pwr_on=1 and ready=1 from cycle 5, alu_pwr_en=1 from cycle 1.
- ADD A=0xFFFF, B=0x0001 → done next cycle with result=0x0000, carry=1. SUB A=3, B=5 → result=0xFFFE, carry=1.
- MUL A=0x0102, B=0x0003 → ready=0 for 2 cycles, done on cycle 3 with result=0x0306. A start issued while ready=0 pulses drop and changes no state.
- MUL accepted and pwr_req dropped in the same cycle → DRAIN, done with result=0x0306, then PDN for 1 cycle, then OFF. Re-power shows result=0 once ON.
- Opcode 12 → done with result=0. SHL A=0x0001, B=0x0013 → result=0x0008 (shift amount 3).
- rst_n pulsed low during MUL busy → all outputs return to reset values immediately, with no done pulse.

Source files
------------

// File: rtl/pg_alu_pkg.sv
// Shared types for the power-managed ALU block.
// Opcode and power-state encodings plus a small decode helper.
package pg_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_MUL  = 4'd8,
        OP_PASS = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        PS_OFF,
        PS_PUP,
        PS_ON,
        PS_DRAIN,
        PS_PDN
    } ps_e;

    function automatic logic is_mul(input logic [3:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/pg_alu_datapath.sv
// ALU datapath: op decode, multi-cycle MUL, result/carry hold, done pulse.
// Ports: clk, rst_n, clr, accept, a, b, opcode -> busy, done, result, carry.
module pg_alu_datapath
    import pg_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             accept,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(MUL_LAT + 1);

    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             done_q;
    logic [WIDTH-1:0] mul_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] mul_lo;

    assign sum    = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the unsigned borrow (a < b).
    assign diff   = {1'b0, a} - {1'b0, b};
    assign shamt  = b[SW-1:0];
    assign mul_lo = a * b;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        unique case (1'b1)
            (opcode == OP_ADD): begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            (opcode == OP_SUB): begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
            end
            (opcode == OP_AND):  alu_res = a & b;
            (opcode == OP_OR):   alu_res = a | b;
            (opcode == OP_XOR):  alu_res = a ^ b;
            (opcode == OP_NOT):  alu_res = ~a;
            (opcode == OP_SHL):  alu_res = a << shamt;
            (opcode == OP_SHR):  alu_res = a >> shamt;
            (opcode == OP_PASS): alu_res = a;
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // The product is captured at accept; the counter only models latency
    // and loads the result register on its final tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            mul_q   <= '0;
            cnt     <= '0;
        end else if (clr) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            mul_q   <= '0;
            cnt     <= '0;
        end else begin
            done_q <= 1'b0;
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    res_q   <= mul_q;
                    carry_q <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
            if (accept) begin
                if (is_mul(opcode)) begin
                    mul_q <= mul_lo;
                    cnt   <= CW'(MUL_LAT - 1);
                end else begin
                    res_q   <= alu_res;
                    carry_q <= alu_carry;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign busy   = (cnt != '0);
    assign done   = done_q;
    assign result = res_q;
    assign carry  = carry_q;

endmodule

// File: rtl/pg_alu_ctrl.sv
// Power-managed ALU: power sequencer, settle counter, handshake, clamp.
// Ports: clk, rst_n, pwr_req, A, B, opcode, start -> ready, done, result,
//        carry, alu_pwr_en, iso_en, pwr_on, drop.
module pg_alu_ctrl
    import pg_alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PWR_UP_CYC = 4,
    parameter int MUL_LAT    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwr_req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    input  logic             start,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             alu_pwr_en,
    output logic             iso_en,
    output logic             pwr_on,
    output logic             drop
);

    localparam int SCW = $clog2(PWR_UP_CYC + 1);

    ps_e              ps;
    ps_e              ps_nx;
    logic [SCW-1:0]   settle;

    logic             busy;
    logic             accept;
    logic             clr;
    logic             dp_done;
    logic [WIDTH-1:0] dp_result;
    logic             dp_carry;

    assign pwr_on     = (ps == PS_ON);
    assign alu_pwr_en = (ps != PS_OFF);
    assign iso_en     = !((ps == PS_ON) || (ps == PS_DRAIN));
    assign ready      = pwr_on && !busy;
    assign accept     = start && ready;
    assign drop       = start && !ready;
    // PDN always exits to OFF, so clearing there empties the datapath
    // on entry to OFF; holding it in OFF keeps it empty.
    assign clr        = (ps == PS_PDN) || (ps == PS_OFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps     <= PS_OFF;
            settle <= '0;
        end else begin
            ps <= ps_nx;
            if (ps == PS_PUP) begin
                settle <= settle + SCW'(1);
            end else begin
                settle <= '0;
            end
        end
    end

    always_comb begin
        ps_nx = ps;
        unique case (ps)
            PS_OFF: begin
                if (pwr_req) ps_nx = PS_PUP;
            end
            PS_PUP: begin
                if (!pwr_req) begin
                    ps_nx = PS_PDN;
                end else if (settle == SCW'(PWR_UP_CYC - 1)) begin
                    ps_nx = PS_ON;
                end
            end
            PS_ON: begin
                // A MUL accepted this cycle is already in flight.
                if (!pwr_req) begin
                    if (busy || (accept && is_mul(opcode))) begin
                        ps_nx = PS_DRAIN;
                    end else begin
                        ps_nx = PS_PDN;
                    end
                end
            end
            PS_DRAIN: begin
                if (dp_done) ps_nx = PS_PDN;
            end
            PS_PDN: begin
                ps_nx = PS_OFF;
            end
            default: begin
                ps_nx = PS_OFF;
            end
        endcase
    end

    pg_alu_datapath #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .accept (accept),
        .a      (A),
        .b      (B),
        .opcode (opcode),
        .busy   (busy),
        .done   (dp_done),
        .result (dp_result),
        .carry  (dp_carry)
    );

    assign done   = dp_done;
    assign result = iso_en ? '0 : dp_result;
    assign carry  = !iso_en && dp_carry;

endmodule

// File: tb/tb_pg_alu_ctrl.sv
// Testbench for pg_alu_ctrl: scoreboard queue with a decoupled monitor.
// Expected results come from a plain-arithmetic reference model.
module tb_pg_alu_ctrl;

    localparam int W   = 16;
    localparam int PUC = 4;
    localparam int ML  = 3;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pwr_req = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [3:0]   opcode = '0;

    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         alu_pwr_en;
    logic         iso_en;
    logic         pwr_on;
    logic         drop;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];
    exp_t me;

    bit           model_on = 1'b0;
    int           free_at = 0;
    logic [W-1:0] held_res = '0;
    logic         held_c = 1'b0;

    pg_alu_ctrl #(
        .WIDTH      (W),
        .PWR_UP_CYC (PUC),
        .MUL_LAT    (ML)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwr_req    (pwr_req),
        .A          (a_in),
        .B          (b_in),
        .opcode     (opcode),
        .start      (start),
        .ready      (ready),
        .done       (done),
        .result     (result),
        .carry      (carry),
        .alu_pwr_en (alu_pwr_en),
        .iso_en     (iso_en),
        .pwr_on     (pwr_on),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [W:0] ref_op(input int op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint m  = longint'(1) << W;
        longint r  = 0;
        logic   c  = 1'b0;
        case (op)
            0: begin
                r = ua + ub;
                c = (r >= m);
                r = r % m;
            end
            1: begin
                r = (ua - ub + m) % m;
                c = (ua < ub);
            end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: r = (m - 1) - ua;
            6: r = (ua << (ub % W)) % m;
            7: r = ua >> (ub % W);
            8: r = (ua * ub) % m;
            9: r = ua;
            default: r = 0;
        endcase
        return {c, r[W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_alu_pwr_en", alu_pwr_en, 0);
        chk("rst_iso_en", iso_en, 1);
        chk("rst_pwr_on", pwr_on, 0);
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_drop", drop, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
    endtask

    task automatic issue(input int op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        logic       exp_rdy;
        logic [W:0] r;
        exp_t       e;
        exp_rdy = model_on && (cyc >= free_at);
        start  = 1'b1;
        opcode = 4'(op);
        a_in   = a;
        b_in   = b;
        if (exp_rdy) begin
            r     = ref_op(op, a, b);
            e.res = r[W-1:0];
            e.c   = r[W];
            e.due = cyc + ((op == 8) ? ML : 1);
            q.push_back(e);
            held_res = e.res;
            held_c   = e.c;
            if (op == 8) free_at = cyc + ML;
        end
        @(negedge clk);
        chk("ready", ready, exp_rdy);
        chk("drop", drop, !exp_rdy);
        step();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_ready", ready, model_on && (cyc >= free_at));
            chk("idle_drop", drop, 0);
            if (model_on && q.size() == 0) begin
                chk("hold_result", result, held_res);
                chk("hold_carry", carry, held_c);
            end
            step();
        end
    endtask

    task automatic power_up();
        pwr_req = 1'b1;
        for (int k = 0; k <= PUC + 1; k++) begin
            @(negedge clk);
            chk("pup_alu_pwr_en", alu_pwr_en, k >= 1);
            chk("pup_iso_en", iso_en, k <= PUC);
            chk("pup_pwr_on", pwr_on, k > PUC);
            chk("pup_ready", ready, k > PUC);
            step();
        end
        model_on = 1'b1;
        free_at  = cyc;
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                me = q.pop_front();
                chk("done_cycle", cyc, me.due);
                chk("result", result, me.res);
                chk("carry", carry, me.c);
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            chk("done_missing", 0, 1);
            void'(q.pop_front());
        end
    end

    initial begin
        int op;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
        step();
        step();

        power_up();

        issue(0, 16'hFFFF, 16'h0001);
        issue(1, 16'h0003, 16'h0005);
        idle(1);

        issue(8, 16'h0102, 16'h0003);
        issue(0, 16'h0001, 16'h0001);
        issue(2, 16'h00FF, 16'h0F0F);
        issue(4, 16'hA5A5, 16'h0FF0);
        idle(2);

        issue(12, 16'h1234, 16'h5678);
        issue(6, 16'h0001, 16'h0013);
        issue(7, 16'h8000, 16'h0014);
        issue(9, 16'hBEEF, 16'h0000);
        issue(5, 16'h00F0, 16'h0000);
        idle(2);

        repeat (300) begin
            if ($urandom_range(0, 2) == 0) begin
                idle(1);
            end else begin
                op = ($urandom_range(0, 3) == 0) ? 8 : int'($urandom_range(0, 15));
                issue(op, W'($urandom), W'($urandom));
            end
        end
        idle(4);

        pwr_req = 1'b0;
        issue(8, 16'h0102, 16'h0003);
        model_on = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("dn_alu_pwr_en", alu_pwr_en, k <= 4);
            chk("dn_iso_en", iso_en, k >= 4);
            chk("dn_pwr_on", pwr_on, 0);
            chk("dn_ready", ready, 0);
            if (k == 4) chk("pdn_clamp", result, 0);
            step();
        end
        held_res = '0;
        held_c   = 1'b0;

        power_up();
        idle(2);

        issue(8, 16'h1111, 16'h0007);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset();
        q.delete();
        model_on = 1'b0;
        pwr_req  = 1'b0;
        idle(4);
        chk_reset();
        rst_n = 1'b1;
        idle(2);

        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
